// File: rtl/sdram_test_pkg.sv
// Shared FSM state type, watchdog limit and write/read-back data pattern for the SDRAM tester.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_MAX = 16'hFFFF;
  localparam int unsigned PAT_W       = 64;

  // P(idx) = mult*idx + offset at full width; caller truncates to the data width.
  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] idx,
                                           input logic [PAT_W-1:0] mult,
                                           input logic [PAT_W-1:0] offset,
                                           input logic             inv);
    logic [PAT_W-1:0] p;
    p = (mult * idx) + offset;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational pattern generator, shared by write data and read-back compare.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MULT   = 3,
  parameter int unsigned OFFSET = 7
) (
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_inv,
  output logic [DATA_W-1:0] o_pattern_c
);

  always_comb begin
    o_pattern_c = DATA_W'(pat(PAT_W'(i_idx), PAT_W'(MULT), PAT_W'(OFFSET), i_inv));
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM write/read-back self-test engine on an Avalon-style master port.
// Optional watchdog and timeout output enabled by defining SDRAM_TESTER_TIMEOUT_EN.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int unsigned     ADDR_W = 25,
  parameter int unsigned     DATA_W = 16,
  parameter int unsigned     DEPTH  = 65536,
  parameter longint unsigned BASE   = 0,
  parameter int unsigned     MULT   = 3,
  parameter int unsigned     OFFSET = 7,
  parameter int unsigned     ERR_W  = 16
) (
  input  logic              MAIN_CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              invert,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_write_n,
  output logic              avm_read_n,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
`ifdef SDRAM_TESTER_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic [7:0]        progress
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     PROG_W   = (IDX_W < 8) ? 8 : IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_inv, w_inv_nxt;
  logic                w_load;
  logic [DATA_W-1:0]   w_pat;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write_n, w_write_n_nxt;
  logic                r_read_n, w_read_n_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic [ADDR_W-1:0]   r_ffail, w_ffail_nxt;
  logic                w_wdog_exp;
  logic                w_timeout;

  // r_wdata doubles as the compare reference while reading back.
  sdram_pattern_gen #(
    .IDX_W (IDX_W),
    .DATA_W(DATA_W),
    .MULT  (MULT),
    .OFFSET(OFFSET)
  ) u_gen (
    .i_idx      (w_idx_nxt),
    .i_inv      (w_inv_nxt),
    .o_pattern_c(w_pat)
  );

`ifdef SDRAM_TESTER_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;
  logic        w_active;
  logic        w_xfer;

  assign w_active   = (r_state == WRITE) || (r_state == READ_REQ) || (r_state == READ_WAIT);
  assign w_xfer     = (((r_state == WRITE) || (r_state == READ_REQ)) && !avm_waitrequest)
                      || ((r_state == READ_WAIT) && avm_readdatavalid);
  assign w_wdog_exp = w_active && (r_wdog == TIMEOUT_MAX);
  assign w_timeout  = r_timeout;
  assign timeout    = r_timeout;

  // Watchdog restarts on any completed transfer or returned read data.
  always_ff @(posedge MAIN_CLK) begin
    if (RESET) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_wdog    <= '0;
        r_timeout <= 1'b0;
      end
    end else if (w_active) begin
      if (w_wdog_exp)  r_timeout <= 1'b1;
      else if (w_xfer) r_wdog    <= '0;
      else             r_wdog    <= r_wdog + 16'd1;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
  assign w_timeout  = 1'b0;
`endif

  always_ff @(posedge MAIN_CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (start) w_state_nxt = WRITE;
      WRITE:     if (!avm_waitrequest && (r_idx == LAST_IDX)) w_state_nxt = READ_REQ;
      READ_REQ:  if (!avm_waitrequest) w_state_nxt = READ_WAIT;
      READ_WAIT: if (avm_readdatavalid) w_state_nxt = (r_idx == LAST_IDX) ? DONE : READ_REQ;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_wdog_exp) w_state_nxt = DONE;
  end

  always_comb begin
    w_idx_nxt     = r_idx;
    w_inv_nxt     = r_inv;
    w_load        = 1'b0;
    w_write_n_nxt = r_write_n;
    w_read_n_nxt  = r_read_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_err_nxt     = r_err;
    w_ffail_nxt   = r_ffail;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_inv_nxt     = invert;
          w_idx_nxt     = '0;
          w_load        = 1'b1;
          w_write_n_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = '0;
          w_ffail_nxt   = '0;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          w_load = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt     = '0;
            w_write_n_nxt = 1'b1;
            w_read_n_nxt  = 1'b0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      READ_REQ: begin
        if (!avm_waitrequest) w_read_n_nxt = 1'b1;
      end
      READ_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata != r_wdata) begin
            if (r_err != {ERR_W{1'b1}}) w_err_nxt = r_err + ERR_W'(1);
            if (r_err == '0)            w_ffail_nxt = r_addr;
          end
          if (r_idx != LAST_IDX) begin
            w_idx_nxt    = r_idx + IDX_W'(1);
            w_load       = 1'b1;
            w_read_n_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        w_pass_nxt = (r_err == '0) && !w_timeout;
      end
      default: ;
    endcase
    if (w_wdog_exp) begin
      w_write_n_nxt = 1'b1;
      w_read_n_nxt  = 1'b1;
    end
  end

  always_ff @(posedge MAIN_CLK) begin
    if (RESET) begin
      r_idx     <= '0;
      r_inv     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write_n <= 1'b1;
      r_read_n  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ffail   <= '0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_inv     <= w_inv_nxt;
      r_write_n <= w_write_n_nxt;
      r_read_n  <= w_read_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_err     <= w_err_nxt;
      r_ffail   <= w_ffail_nxt;
      if (w_load) begin
        r_addr  <= ADDR_W'(BASE + 64'(w_idx_nxt));
        r_wdata <= w_pat;
      end
    end
  end

  assign avm_address     = r_addr;
  assign avm_writedata   = r_wdata;
  assign avm_write_n     = r_write_n;
  assign avm_read_n      = r_read_n;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_addr = r_ffail;
  assign progress        = 8'(PROG_W'(r_idx) >> (PROG_W - 8));

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench: two tester instances (BASE 0 / DEPTH 16 and wrapping BASE / DEPTH 8) on SDRAM models.
module tb_sdram_pattern_tester;

  localparam int unsigned     AW    = 25;
  localparam int unsigned     DW    = 16;
  localparam int unsigned     NI    = 2;
  localparam longint unsigned BASE1 = 64'h1FF_FFFC;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wrec_t;

  typedef struct {
    int            g;
    bit            inv;
    bit            rnd;
    int            lmin;
    int            lmax;
    logic [31:0]   cmask;
    bit            ep;
    int            ee;
    logic [AW-1:0] ef;
  } vec_t;

  logic clk;
  logic rst;
  logic          start [NI];
  logic          invert [NI];
  logic [AW-1:0] addr [NI];
  logic [DW-1:0] wdata [NI];
  logic          write_n [NI];
  logic          read_n [NI];
  logic          waitreq [NI];
  logic [DW-1:0] rdata [NI];
  logic          rdv [NI];
  logic          busy [NI];
  logic          done [NI];
  logic          pass [NI];
  logic [15:0]   err [NI];
  logic [AW-1:0] ffa [NI];
  logic [7:0]    prog [NI];
`ifdef SDRAM_TESTER_TIMEOUT_EN
  logic          tmo [NI];
`endif

  bit          rnd_wait [NI];
  bit          stuck [NI];
  int          lat_min [NI];
  int          lat_max [NI];
  logic [31:0] cmask [NI];
  wrec_t       wlog [NI][$];
  int          rd_n [NI];
  int          stall_err [NI];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    sdram_pattern_tester #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH((g == 0) ? 16 : 8),
      .BASE((g == 0) ? 64'd0 : BASE1), .MULT(3), .OFFSET(7), .ERR_W(16)
    ) u_dut (
      .MAIN_CLK(clk), .RESET(rst), .start(start[g]), .invert(invert[g]),
      .avm_address(addr[g]), .avm_writedata(wdata[g]),
      .avm_write_n(write_n[g]), .avm_read_n(read_n[g]),
      .avm_waitrequest(waitreq[g]), .avm_readdata(rdata[g]),
      .avm_readdatavalid(rdv[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_count(err[g]), .first_fail_addr(ffa[g]),
`ifdef SDRAM_TESTER_TIMEOUT_EN
      .timeout(tmo[g]),
`endif
      .progress(prog[g])
    );

    logic [DW-1:0] mem [32];
    logic [AW-1:0] m_raddr, p_addr;
    logic [DW-1:0] p_data;
    logic          p_wait, p_wn, p_rn;
    bit            m_pend;
    int            m_cnt;
    wrec_t         m_rec;

    // Memory model: updates 1ns after the falling edge, so the DUT sees stable inputs at the rising edge.
    always @(negedge clk) begin
      #1;
      if (rst) begin
        m_pend     = 1'b0;
        rdv[g]     = 1'b0;
        waitreq[g] = 1'b0;
        p_wait     = 1'b0;
      end else begin
        if (!stuck[g] && p_wait && (!p_wn || !p_rn) &&
            (addr[g] != p_addr || write_n[g] != p_wn || read_n[g] != p_rn ||
             (!p_wn && wdata[g] != p_data)))
          stall_err[g]++;
        rdv[g] = 1'b0;
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            rdv[g]   = 1'b1;
            rdata[g] = mem[m_raddr[4:0]] ^ DW'(cmask[g][m_raddr[4:0]]);
            m_pend   = 1'b0;
          end
        end
        waitreq[g] = stuck[g] ? 1'b1 : (rnd_wait[g] ? 1'($urandom_range(0, 1)) : 1'b0);
        if (!write_n[g] && !waitreq[g]) begin
          mem[addr[g][4:0]] = wdata[g];
          m_rec.a = addr[g];
          m_rec.d = wdata[g];
          m_rec.c = 32'(cyc);
          wlog[g].push_back(m_rec);
        end
        if (!read_n[g] && !waitreq[g]) begin
          m_pend  = 1'b1;
          m_raddr = addr[g];
          m_cnt   = $urandom_range(lat_min[g], lat_max[g]);
          rd_n[g]++;
        end
        p_wait = waitreq[g];
        p_addr = addr[g];
        p_data = wdata[g];
        p_wn   = write_n[g];
        p_rn   = read_n[g];
      end
    end
  end

  function automatic logic [DW-1:0] exp_pat(input int i, input bit inv);
    logic [DW-1:0] p;
    p = DW'(3 * i + 7);
    return inv ? ~p : p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_knobs(input int g, input bit rnd, input int lmin, input int lmax,
                           input logic [31:0] mask);
    rnd_wait[g] = rnd;
    lat_min[g]  = lmin;
    lat_max[g]  = lmax;
    cmask[g]    = mask;
  endtask

  task automatic launch(input int g, input bit inv);
    @(negedge clk);
    invert[g] = inv;
    start[g]  = 1'b1;
    @(negedge clk);
    start[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output bit fin);
    for (int i = 0; i < budget; i++) begin
      if (done[g]) break;
      @(negedge clk);
    end
    fin = done[g];
  endtask

  task automatic check_run(input int g, input bit inv, input bit rnd, input bit fin,
                           input int wb, input int rb, input int sb, input bit ep,
                           input int ee, input logic [AW-1:0] ef, input string tag);
    int            dep;
    int            n;
    int            bad;
    logic [AW-1:0] base;
    dep  = (g == 0) ? 16 : 8;
    base = (g == 0) ? '0 : AW'(BASE1);
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_busy"}, 64'(busy[g]), 64'd0);
    chk({tag, "_pass"}, 64'(pass[g]), 64'(ep));
    chk({tag, "_err_count"}, 64'(err[g]), 64'(ee));
    chk({tag, "_first_fail"}, 64'(ffa[g]), 64'(ef));
    n = wlog[g].size() - wb;
    chk({tag, "_writes"}, 64'(n), 64'(dep));
    chk({tag, "_reads"}, 64'(rd_n[g] - rb), 64'(dep));
    bad = 0;
    for (int i = 0; i < dep; i++) begin
      if (wb + i < wlog[g].size()) begin
        if (wlog[g][wb + i].a != base + AW'(i) || wlog[g][wb + i].d != exp_pat(i, inv)) bad++;
      end
    end
    chk({tag, "_write_addr_data_errors"}, 64'(bad), 64'd0);
    if (!rnd && n >= dep)
      chk({tag, "_b2b_span"}, 64'(wlog[g][wb + dep - 1].c - wlog[g][wb].c), 64'(dep - 1));
    chk({tag, "_stall_changes"}, 64'(stall_err[g] - sb), 64'd0);
  endtask

  vec_t vt [5];
  int   g, wb, rb, sb;
  bit   fin;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      invert[i] = 1'b0;
      stuck[i] = 1'b0;
      rd_n[i] = 0;
      stall_err[i] = 0;
      set_knobs(i, 1'b0, 1, 1, 32'h0);
    end
    vt[0] = '{0, 1'b0, 1'b0, 1, 1, 32'h0000_0000, 1'b1, 0, 25'h0};
    vt[1] = '{0, 1'b0, 1'b0, 1, 1, 32'h0000_0220, 1'b0, 2, 25'h5};
    vt[2] = '{0, 1'b1, 1'b1, 2, 6, 32'h0000_0000, 1'b1, 0, 25'h0};
    vt[3] = '{1, 1'b0, 1'b0, 1, 1, 32'h0000_0000, 1'b1, 0, 25'h0};
    vt[4] = '{1, 1'b1, 1'b1, 2, 6, 32'h0000_0002, 1'b0, 1, 25'h1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write_n", 64'(write_n[0]), 64'd1);
    chk("rst_read_n", 64'(read_n[0]), 64'd1);
    chk("rst_address", 64'(addr[0]), 64'd0);
    chk("rst_writedata", 64'(wdata[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_done", 64'(done[0]), 64'd0);
    chk("rst_pass", 64'(pass[0]), 64'd0);
    chk("rst_err_count", 64'(err[0]), 64'd0);
    chk("rst_first_fail", 64'(ffa[0]), 64'd0);
    chk("rst_progress", 64'(prog[0]), 64'd0);
    chk("rst_g1_address", 64'(addr[1]), 64'd0);
    rst = 1'b0;

    // Table of full runs
    for (int v = 0; v < 5; v++) begin
      g = vt[v].g;
      set_knobs(g, vt[v].rnd, vt[v].lmin, vt[v].lmax, vt[v].cmask);
      wb = wlog[g].size();
      rb = rd_n[g];
      sb = stall_err[g];
      launch(g, vt[v].inv);
      wait_done(g, 3000, fin);
      check_run(g, vt[v].inv, vt[v].rnd, fin, wb, rb, sb, vt[v].ep, vt[v].ee, vt[v].ef,
                $sformatf("v%0d", v));
    end

    // start (with invert=1) pulsed while busy must not disturb the run
    set_knobs(0, 1'b0, 1, 1, 32'h0);
    wb = wlog[0].size();
    rb = rd_n[0];
    sb = stall_err[0];
    launch(0, 1'b0);
    repeat (4) @(negedge clk);
    launch(0, 1'b1);
    wait_done(0, 3000, fin);
    check_run(0, 1'b0, 1'b0, fin, wb, rb, sb, 1'b1, 0, '0, "start_busy");

    // RESET while waiting for the read of idx 3, then restart from idx 0
    set_knobs(0, 1'b0, 5, 5, 32'h0);
    rb = rd_n[0];
    launch(0, 1'b0);
    fin = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rd_n[0] - rb >= 4) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_reached_idx3", 64'(fin), 64'd1);
    chk("midrst_progress", 64'(prog[0]), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_read_n", 64'(read_n[0]), 64'd1);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_done", 64'(done[0]), 64'd0);
    set_knobs(0, 1'b0, 1, 1, 32'h0);
    wb = wlog[0].size();
    rb = rd_n[0];
    sb = stall_err[0];
    launch(0, 1'b0);
    chk("restart_write_n", 64'(write_n[0]), 64'd0);
    chk("restart_address", 64'(addr[0]), 64'd0);
    chk("restart_writedata", 64'(wdata[0]), 64'd7);
    wait_done(0, 3000, fin);
    check_run(0, 1'b0, 1'b0, fin, wb, rb, sb, 1'b1, 0, '0, "restart");

    // start in the same cycle as RESET is dropped
    @(negedge clk);
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    chk("rst_start_busy", 64'(busy[0]), 64'd0);
    chk("rst_start_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    chk("rst_start_write_n", 64'(write_n[0]), 64'd1);
    chk("rst_start_busy_after", 64'(busy[0]), 64'd0);

`ifdef SDRAM_TESTER_TIMEOUT_EN
    // Watchdog: controller never releases waitrequest
    stuck[0] = 1'b1;
    launch(0, 1'b0);
    wait_done(0, 70000, fin);
    chk("tmo_finished", 64'(fin), 64'd1);
    chk("tmo_timeout", 64'(tmo[0]), 64'd1);
    chk("tmo_pass", 64'(pass[0]), 64'd0);
    chk("tmo_write_n", 64'(write_n[0]), 64'd1);
    chk("tmo_busy", 64'(busy[0]), 64'd0);
    stuck[0] = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Parametrised SDRAM write/read-back self-test engine.
- Drives the Avalon-style port of the SDRAM controller.
- Fills a configurable address window with an arithmetic data pattern, then reads every word back and compares it.
- Reports pass/fail, error count and first failing address to the top level (LEDs/HEX).

Parameters:
- ADDR_W, 25, controller word-address width.
- DATA_W, 16, data word width.
- DEPTH, 65536, number of words tested (>=2).
- BASE, 0, first tested address.
- MULT, 3, pattern multiplier.
- OFFSET, 7, pattern offset.
- ERR_W, 16, error counter width.

Ports:
- MAIN_CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin a test run
- invert  in  1  sampled at start; if 1, the pattern is bitwise inverted
- avm_address  out  ADDR_W  controller address
- avm_writedata  out  DATA_W  write data
- avm_write_n  out  1  write request, active low
- avm_read_n  out  1  read request, active low
- avm_waitrequest  in  1  controller stall, active high
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  run in progress
- done  out  1  run finished; sticky until next start or RESET
- pass  out  1  valid when done; 1 = zero mismatches
- err_count  out  ERR_W  mismatch count, saturating
- first_fail_addr  out  ADDR_W  address of first mismatch
- progress  out  8  index[MSB-7:MSB] of current word counter

Behaviour:
- Reset values:
  - avm_write_n = 1, avm_read_n = 1, address/writedata = 0.
  - busy = 0, done = 0, pass = 0, err_count = 0, first_fail_addr = 0.
  - FSM in IDLE; all requests deasserted in the same cycle.
- Word index idx counts 0..DEPTH-1, width $clog2(DEPTH).
- Address is BASE + idx, truncated to ADDR_W.
- Pattern P(idx) = (MULT*idx + OFFSET) mod 2^DATA_W, computed at full width then truncated. If inverted, ~P.
- FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- IDLE:
  - On start: latch invert, idx = 0, clear err_count/first_fail_addr/done/pass, busy = 1, go to WRITE.
- WRITE:
  - Drive avm_write_n = 0 with address/data for idx.
  - Signals stay stable while avm_waitrequest = 1.
  - A transfer completes on a cycle with write_n = 0 and waitrequest = 0.
  - On completion: if idx = DEPTH-1, set idx = 0 and go to READ_REQ; else idx++.
  - Back-to-back writes allowed: one word per cycle at zero wait.
- READ_REQ:
  - Drive avm_read_n = 0 until accepted (waitrequest = 0), then deassert and go to READ_WAIT.
  - Only one read is outstanding.
- READ_WAIT:
  - On avm_readdatavalid, compare avm_readdata against the expected pattern.
  - On mismatch: err_count++ (saturates at all-ones). If this is the first mismatch, first_fail_addr = address.
  - Then, if idx = DEPTH-1, go to DONE; else idx++ and go to READ_REQ.
  - readdatavalid outside READ_WAIT is ignored.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0), registered one cycle after entry.
  - Then return to IDLE, keeping done/pass/err/first_fail.
- start while busy is ignored.
- start in the same cycle as RESET: RESET wins.
- RESET mid-run aborts immediately; the SDRAM contents are left undefined.
- Address wrap: BASE + DEPTH past 2^ADDR_W wraps modulo 2^ADDR_W; no error is flagged.
- waitrequest held high indefinitely: the FSM stalls, busy stays 1; no timeout unless the optional feature is enabled.

Optional Feature:
- Macro: SDRAM_TESTER_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit watchdog, reset on every completed transfer or readdatavalid.
  - On reaching 16'hFFFF in WRITE/READ_REQ/READ_WAIT: requests deasserted, FSM goes to DONE with pass = 0.
  - An extra output timeout (1 bit, reset 0, sticky until start) is set.
- Undefined:
  - No watchdog, no timeout port.
  - Stalls persist until RESET.

Decomposition:
- Package sdram_test_pkg:
  - state_t enum (IDLE, WRITE, READ_REQ, READ_WAIT, DONE).
  - pattern function pat(idx, mult, offset, inv, width-truncated).
  - TIMEOUT_MAX constant.
- One natural sub-module: sdram_pattern_gen.
  - Combinational/registered P(idx) generator, shared by write data and read compare.

Test Plan:
- Zero-wait model, DEPTH = 16, BASE = 0, invert = 0 -> 16 writes with data 7, 10, ..., 52 in 16 consecutive cycles; 16 reads; done = 1, pass = 1, err_count = 0.
- Model corrupts addr 5 (readdata ^ 1) and addr 9 -> pass = 0, err_count = 2, first_fail_addr = 5.
- Random waitrequest (50%) and 2-6 cycle read latency, invert = 1 -> writedata = ~(3*idx+7); signals stable during stalls; pass = 1.
- BASE = 2^ADDR_W - 4, DEPTH = 8 -> addresses ...FFC-...FFF then 0-3; pass = 1.
- RESET asserted during READ_WAIT at idx 3 -> next cycle read_n = 1, busy = 0, done = 0; new start restarts at idx 0 WRITE.
- start pulsed while busy -> no effect. With SDRAM_TESTER_TIMEOUT_EN and waitrequest stuck at 1 -> timeout = 1, done = 1, pass = 0 after 65535 cycles.
